// File: rtl/port_write_arbiter_if.sv
// Port write path bundle: two requesters (CPU, magic) plus the timed pw_* bus to the register bank.
// master = requester/decode side, slave = arbiter.
interface port_write_arbiter_if;
    logic        clkcpu_ck;
    logic        cpu_block;
    logic        cpu_req;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_ack;
    logic        mgc_req;
    logic [15:0] mgc_a;
    logic [7:0]  mgc_d;
    logic        mgc_ack;
    logic        pw_stb;
    logic [15:0] pw_a;
    logic [7:0]  pw_d;
    logic        pw_src;
    logic        busy;

    modport master (
        output clkcpu_ck, cpu_block,
        output cpu_req, cpu_a, cpu_d,
        output mgc_req, mgc_a, mgc_d,
        input  cpu_ack, mgc_ack,
        input  pw_stb, pw_a, pw_d, pw_src, busy
    );

    modport slave (
        input  clkcpu_ck, cpu_block,
        input  cpu_req, cpu_a, cpu_d,
        input  mgc_req, mgc_a, mgc_d,
        output cpu_ack, mgc_ack,
        output pw_stb, pw_a, pw_d, pw_src, busy
    );
endinterface

// File: rtl/port_write_arbiter.sv
// Round-robin arbiter for the port write path; grant-to-ack is SETUP_CYC+STB_CYC+HOLD_CYC+1 cycles.
// Requests are levels held until ack; nothing new is accepted outside IDLE.
module port_write_arbiter #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned STB_CYC   = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                 clk28,
    input  logic                 rst,
    port_write_arbiter_if.slave  pw
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

    localparam logic [2:0] C_SETUP = 3'(SETUP_CYC);
    localparam logic [2:0] C_STB   = 3'(STB_CYC);
    localparam logic [2:0] C_HOLD  = 3'(HOLD_CYC);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_last;
    logic        r_src;
    logic [15:0] r_a;
    logic [7:0]  r_d;

    logic        w_cpu_ok;
    logic        w_mgc_ok;
    logic        w_grant;
    logic        w_win;

    // CPU is only eligible on a CPU clock-edge cycle and never while magic owns the machine.
    assign w_cpu_ok = pw.cpu_req & pw.clkcpu_ck & ~pw.cpu_block;
    assign w_mgc_ok = pw.mgc_req;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_win       = r_src;
        case (r_state)
            IDLE: begin
                if (w_cpu_ok | w_mgc_ok) begin
                    w_grant = 1'b1;
                    w_win   = (w_cpu_ok & w_mgc_ok) ? ~r_last : w_mgc_ok;
                    if (C_SETUP != 3'd0) begin
                        w_state_nxt = SETUP;
                        w_cnt_nxt   = C_SETUP;
                    end else begin
                        w_state_nxt = STROBE;
                        w_cnt_nxt   = C_STB;
                    end
                end
            end
            SETUP: begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = C_STB;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            STROBE: begin
                if (r_cnt == 3'd1) begin
                    if (C_HOLD != 3'd0) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = C_HOLD;
                    end else begin
                        w_state_nxt = ACK;
                        w_cnt_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            HOLD: begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = ACK;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // last resets to magic so the CPU wins the first tie.
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_last  <= 1'b1;
            r_src   <= 1'b0;
            r_a     <= 16'h0000;
            r_d     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_last <= w_win;
                r_src  <= w_win;
                r_a    <= w_win ? pw.mgc_a : pw.cpu_a;
                r_d    <= w_win ? pw.mgc_d : pw.cpu_d;
            end
        end
    end

    // Outputs decode straight from registered state, so they never depend on live requests.
    assign pw.pw_stb  = (r_state == STROBE);
    assign pw.busy    = (r_state != IDLE);
    assign pw.cpu_ack = (r_state == ACK) & ~r_src;
    assign pw.mgc_ack = (r_state == ACK) &  r_src;
    assign pw.pw_a    = r_a;
    assign pw.pw_d    = r_d;
    assign pw.pw_src  = r_src;

    a_ack_excl: assert property (@(posedge clk28) disable iff (rst)
        !(pw.cpu_ack && pw.mgc_ack));
    a_stb_busy: assert property (@(posedge clk28) disable iff (rst)
        pw.pw_stb |-> pw.busy);

endmodule

// File: tb/tb_port_write_arbiter.sv
// Bench for port_write_arbiter: default timing instance (A) and a SETUP=0/STB=1/HOLD=0 instance (B).
module tb_port_write_arbiter;

    logic clk28 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk28 = ~clk28;

    port_write_arbiter_if ifa ();
    port_write_arbiter_if ifb ();

    port_write_arbiter #(.SETUP_CYC(1), .STB_CYC(2), .HOLD_CYC(1)) dut_a (
        .clk28 (clk28),
        .rst   (rst),
        .pw    (ifa)
    );

    port_write_arbiter #(.SETUP_CYC(0), .STB_CYC(1), .HOLD_CYC(0)) dut_b (
        .clk28 (clk28),
        .rst   (rst),
        .pw    (ifb)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: each instance is either idle or t cycles into a transaction.
    int          p_s [2] = '{1, 0};
    int          p_t [2] = '{2, 1};
    int          p_h [2] = '{1, 0};
    bit          m_busy [2];
    int          m_t    [2];
    bit          m_last [2];
    bit          m_src  [2];
    logic [15:0] m_a    [2];
    logic [7:0]  m_d    [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit cr, input bit ck, input bit blk, input bit mr,
                              input logic [15:0] ca, input logic [7:0] cd,
                              input logic [15:0] ma, input logic [7:0] md);
        bit cok;
        bit mok;
        bit win;
        if (rst) begin
            m_busy[i] = 1'b0; m_t[i] = 0; m_last[i] = 1'b1;
            m_src[i]  = 1'b0; m_a[i] = 16'h0; m_d[i] = 8'h0;
        end else if (!m_busy[i]) begin
            cok = cr && ck && !blk;
            mok = mr;
            if (cok || mok) begin
                win = (cok && mok) ? !m_last[i] : mok;
                m_busy[i] = 1'b1; m_t[i] = 1;
                m_src[i]  = win;  m_last[i] = win;
                m_a[i] = win ? ma : ca;
                m_d[i] = win ? md : cd;
            end
        end else if (m_t[i] == p_s[i] + p_t[i] + p_h[i] + 1) begin
            m_busy[i] = 1'b0;
        end else begin
            m_t[i]++;
        end
    endtask

    always @(posedge clk28) begin
        model_step(0, ifa.cpu_req, ifa.clkcpu_ck, ifa.cpu_block, ifa.mgc_req,
                   ifa.cpu_a, ifa.cpu_d, ifa.mgc_a, ifa.mgc_d);
        model_step(1, ifb.cpu_req, ifb.clkcpu_ck, ifb.cpu_block, ifb.mgc_req,
                   ifb.cpu_a, ifb.cpu_d, ifb.mgc_a, ifb.mgc_d);
    end

    task automatic cmp_inst(input int i, input bit busy, input bit stb, input bit cack, input bit mack,
                            input bit src, input logic [15:0] a, input logic [7:0] d);
        int  lat;
        bit  e_stb;
        bit  e_ack;
        lat   = p_s[i] + p_t[i] + p_h[i] + 1;
        e_stb = m_busy[i] && (m_t[i] > p_s[i]) && (m_t[i] <= p_s[i] + p_t[i]);
        e_ack = m_busy[i] && (m_t[i] == lat);
        chk($sformatf("busy[%0d]", i),    32'(busy), 32'(m_busy[i]));
        chk($sformatf("pw_stb[%0d]", i),  32'(stb),  32'(e_stb));
        chk($sformatf("cpu_ack[%0d]", i), 32'(cack), 32'(e_ack && !m_src[i]));
        chk($sformatf("mgc_ack[%0d]", i), 32'(mack), 32'(e_ack && m_src[i]));
        chk($sformatf("pw_src[%0d]", i),  32'(src),  32'(m_src[i]));
        chk($sformatf("pw_a[%0d]", i),    32'(a),    32'(m_a[i]));
        chk($sformatf("pw_d[%0d]", i),    32'(d),    32'(m_d[i]));
    endtask

    always @(negedge clk28) begin
        if (chk_en) begin
            cmp_inst(0, ifa.busy, ifa.pw_stb, ifa.cpu_ack, ifa.mgc_ack, ifa.pw_src, ifa.pw_a, ifa.pw_d);
            cmp_inst(1, ifb.busy, ifb.pw_stb, ifb.cpu_ack, ifb.mgc_ack, ifb.pw_src, ifb.pw_a, ifb.pw_d);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    // Waits (bounded) for an ack on instance A; returns at the negedge where it is seen.
    task automatic wait_ack(input bit mgc, input int budget, output bit ok, output bit other);
        ok    = 1'b0;
        other = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk28);
            if (mgc ? ifa.cpu_ack : ifa.mgc_ack) other = 1'b1;
            if (mgc ? ifa.mgc_ack : ifa.cpu_ack) ok = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit other;
        bit stb_s [7];
        bit ack_s [7];
        bit acks [$];
        int n_c;
        int n_m;
        bit rc;
        bit rm;
        bit prev_ck;
        int first_busy;

        ifa.clkcpu_ck = 1'b1; ifa.cpu_block = 1'b0;
        ifa.cpu_req = 1'b0; ifa.cpu_a = 16'h0; ifa.cpu_d = 8'h0;
        ifa.mgc_req = 1'b0; ifa.mgc_a = 16'h0; ifa.mgc_d = 8'h0;
        ifb.clkcpu_ck = 1'b1; ifb.cpu_block = 1'b0;
        ifb.cpu_req = 1'b0; ifb.cpu_a = 16'h0; ifb.cpu_d = 8'h0;
        ifb.mgc_req = 1'b0; ifb.mgc_a = 16'h0; ifb.mgc_d = 8'h0;

        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk28);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_stb",  32'(ifa.pw_stb), 32'd0);
        chk("rst_pw_a", 32'(ifa.pw_a), 32'd0);
        chk("rst_acks", 32'({ifa.cpu_ack, ifa.mgc_ack}), 32'd0);

        // Single CPU write, default timing.
        tick(1);
        ifa.cpu_req = 1'b1; ifa.cpu_a = 16'h7FFD; ifa.cpu_d = 8'h17;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk28);
            stb_s[k] = ifa.pw_stb;
            ack_s[k] = ifa.cpu_ack;
            if (k == 1) begin
                chk("s1_pw_a", 32'(ifa.pw_a), 32'h7FFD);
                chk("s1_pw_d", 32'(ifa.pw_d), 32'h17);
                chk("s1_src",  32'(ifa.pw_src), 32'd0);
            end
            if (ifa.cpu_ack) ifa.cpu_req = 1'b0;
        end
        chk("s1_stb_pattern", 32'({stb_s[0], stb_s[1], stb_s[2], stb_s[3], stb_s[4], stb_s[5], stb_s[6]}),
            32'b0011000);
        chk("s1_ack_pattern", 32'({ack_s[0], ack_s[1], ack_s[2], ack_s[3], ack_s[4], ack_s[5], ack_s[6]}),
            32'b0000010);

        // Fresh reset, then both requesters contend three times each.
        tick(1); rst = 1'b1; tick(1); rst = 1'b0;
        ifa.cpu_a = 16'h7FFD; ifa.cpu_d = 8'h17;
        ifa.mgc_a = 16'h1FFD; ifa.mgc_d = 8'h04;
        ifa.cpu_req = 1'b1; ifa.mgc_req = 1'b1;
        n_c = 0; n_m = 0;
        for (int c = 0; c < 200 && acks.size() < 6; c++) begin
            @(negedge clk28);
            rc = 1'b0; rm = 1'b0;
            if (ifa.cpu_ack && ifa.mgc_ack) chk("s2_ack_overlap", 32'd1, 32'd0);
            if (ifa.cpu_ack) begin acks.push_back(1'b0); ifa.cpu_req = 1'b0; n_c++; rc = (n_c < 3); end
            if (ifa.mgc_ack) begin acks.push_back(1'b1); ifa.mgc_req = 1'b0; n_m++; rm = (n_m < 3); end
            tick(1);
            if (rc) ifa.cpu_req = 1'b1;
            if (rm) ifa.mgc_req = 1'b1;
        end
        chk("s2_grant_count", 32'(acks.size()), 32'd6);
        for (int g = 0; g < 6 && g < acks.size(); g++)
            chk($sformatf("s2_grant_order_%0d", g), 32'(acks[g]), 32'(g % 2));

        // Magic mode blocks the CPU; releasing the block lets the CPU through.
        tick(1);
        ifa.cpu_block = 1'b1;
        ifa.cpu_a = 16'h00FE; ifa.cpu_d = 8'h05;
        ifa.cpu_req = 1'b1; ifa.mgc_req = 1'b1;
        wait_ack(1'b1, 20, ok, other);
        chk("s3_mgc_served", 32'(ok), 32'd1);
        chk("s3_no_cpu_ack", 32'(other), 32'd0);
        chk("s3_mgc_pw_a", 32'(ifa.pw_a), 32'h1FFD);
        ifa.mgc_req = 1'b0;
        tick(4);
        @(negedge clk28);
        chk("s3_cpu_blocked", 32'(ifa.busy), 32'd0);
        tick(1);
        ifa.cpu_block = 1'b0;
        wait_ack(1'b0, 20, ok, other);
        chk("s3_cpu_served", 32'(ok), 32'd1);
        chk("s3_cpu_pw_d", 32'(ifa.pw_d), 32'h05);
        chk("s3_cpu_pw_a", 32'(ifa.pw_a), 32'h00FE);
        ifa.cpu_req = 1'b0;

        // CPU request only accepted on a clkcpu_ck cycle (one in four).
        tick(2);
        first_busy = -1;
        prev_ck = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ifa.clkcpu_ck = (c % 4 == 3);
            ifa.cpu_req = (first_busy < 0) || !ifa.busy ? (first_busy < 0) : 1'b1;
            @(negedge clk28);
            if (ifa.busy && first_busy < 0) begin
                first_busy = c;
                chk("s4_grant_on_ck", 32'(prev_ck), 32'd1);
            end
            prev_ck = ifa.clkcpu_ck;
            if (ifa.cpu_ack) ifa.cpu_req = 1'b0;
            tick(1);
        end
        chk("s4_first_busy_cycle", 32'(first_busy), 32'd4);
        ifa.cpu_req = 1'b0;
        ifa.clkcpu_ck = 1'b1;

        // Short-timing instance: one-cycle strobe right after grant, ack on grant+2.
        tick(2);
        ifb.cpu_req = 1'b1; ifb.cpu_a = 16'hDFFD; ifb.cpu_d = 8'h07;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk28);
            stb_s[k] = ifb.pw_stb;
            ack_s[k] = ifb.cpu_ack;
            if (ifb.cpu_ack) ifb.cpu_req = 1'b0;
        end
        chk("s5_stb_pattern", 32'({stb_s[0], stb_s[1], stb_s[2], stb_s[3]}), 32'b0100);
        chk("s5_ack_pattern", 32'({ack_s[0], ack_s[1], ack_s[2], ack_s[3]}), 32'b0010);
        chk("s5_pw_a", 32'(ifb.pw_a), 32'hDFFD);

        // Reset mid-strobe abandons the transaction; the CPU wins the re-grant tie.
        tick(2);
        ifa.cpu_a = 16'h7FFD; ifa.cpu_d = 8'hAA;
        ifa.cpu_req = 1'b1; ifa.mgc_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk28);
            if (k == 2) begin
                chk("s6_in_strobe", 32'(ifa.pw_stb), 32'd1);
                rst = 1'b1;
            end
            if (k == 3) begin
                chk("s6_rst_stb",  32'(ifa.pw_stb), 32'd0);
                chk("s6_rst_busy", 32'(ifa.busy), 32'd0);
                chk("s6_rst_acks", 32'({ifa.cpu_ack, ifa.mgc_ack}), 32'd0);
                rst = 1'b0;
            end
            if (k == 4) begin
                chk("s6_regrant_busy", 32'(ifa.busy), 32'd1);
                chk("s6_regrant_src",  32'(ifa.pw_src), 32'd0);
                chk("s6_regrant_d",    32'(ifa.pw_d), 32'hAA);
            end
        end
        wait_ack(1'b0, 20, ok, other);
        chk("s6_cpu_ack", 32'(ok), 32'd1);
        ifa.cpu_req = 1'b0;
        wait_ack(1'b1, 20, ok, other);
        chk("s6_mgc_ack", 32'(ok), 32'd1);
        ifa.mgc_req = 1'b0;

        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
